vga_scanout: RTL and testbench

Consumes the pixel FIFO that the frame address/pixel stage fills and drives a 640x480@60 Hz VGA port. It generates horizontal and vertical timing on the pixel clock. It pops one 24-bit RGB word per active pixel from a first-word-fall-through FIFO. All video outputs are registered so that sync, blank and colour stay cycle-aligned.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_timing_counter.sv | 53 +++++
 rtl/vga_scanout.sv | 123 ++++++++++++
 tb/tb_vga_scanout.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, scanout state enum and pixel packing width.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W = 10;
    localparam int RGB_W = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with active-region and sync-window decode.
// Counters hold at 0 until enabled; decode outputs are combinational from the counters.
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             active,
    output logic             hsync_pre,
    output logic             vsync_pre
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // hsync_pre/vsync_pre are high inside the sync window; the top inverts them.
    assign active    = en && (hcnt < H_VIS) && (vcnt < V_VIS);
    assign hsync_pre = (hcnt >= HS_START) && (hcnt <= HS_END);
    assign vsync_pre = (vcnt >= VS_START) && (vcnt <= VS_END);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: pops one FWFT RGB word per active pixel, registers sync/blank/colour (1 clock to pins).
// An empty FIFO never stalls the raster: the pixel shows UNDERFLOW_RGB and the sticky flag sets.
// Optional SCANOUT_UNDERFLOW_CNT_EN adds a saturating 16-bit underflowed-pixel counter port.
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int          H_ACTIVE      = H_ACTIVE_DEF,
    parameter int          H_FP          = H_FP_DEF,
    parameter int          H_SYNC        = H_SYNC_DEF,
    parameter int          H_BP          = H_BP_DEF,
    parameter int          V_ACTIVE      = V_ACTIVE_DEF,
    parameter int          V_FP          = V_FP_DEF,
    parameter int          V_SYNC        = V_SYNC_DEF,
    parameter int          V_BP          = V_BP_DEF,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [RGB_W-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             frame_start,
`ifdef SCANOUT_UNDERFLOW_CNT_EN
    output logic [15:0]      underflow_cnt,
`endif
    output logic             underflow
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic             active, hsync_pre, vsync_pre;
    logic [RGB_W-1:0] pix;
    logic             pix_underflow;
    logic             first_pix;
    logic [RGB_W-1:0] rgb;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .en        (state == RUN),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .active    (active),
        .hsync_pre (hsync_pre),
        .vsync_pre (vsync_pre)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Scanout starts once the producer has the first word ready, then free-runs.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix           = '0;
        pix_underflow = 1'b0;
        if (active) begin
            if (fifo_empty) begin
                pix           = UNDERFLOW_RGB;
                pix_underflow = 1'b1;
            end else begin
                pix = fifo_dout;
            end
        end
    end

    assign fifo_rd_en = active && !fifo_empty;
    assign first_pix  = active && (hcnt == '0) && (vcnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b1;
            rgb         <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            hsync       <= !hsync_pre;
            vsync       <= !vsync_pre;
            blank       <= !active;
            rgb         <= pix;
            frame_start <= first_pix;
            underflow   <= underflow || pix_underflow;
        end
    end

    assign red   = rgb[23:16];
    assign green = rgb[15:8];
    assign blue  = rgb[7:0];

`ifdef SCANOUT_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         underflow_cnt <= '0;
        else if (pix_underflow && underflow_cnt != '1)   underflow_cnt <= underflow_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: full 800-clock lines, vertical geometry shortened to 8 lines.
module tb_vga_scanout;

    localparam int HT  = 800;
    localparam int HA  = 640;
    localparam int VA  = 4;
    localparam int VT  = 8;
    localparam int FRM = HT * VT;
    localparam int PIX = HA * VA;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [23:0] fifo_dout;
    logic        fifo_rd_en;
    logic        hsync, vsync, blank, frame_start, underflow;
    logic [7:0]  red, green, blue;
`ifdef SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    int unsigned word;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
        .V_ACTIVE (4),   .V_FP (1),  .V_SYNC (2),  .V_BP (1),
        .UNDERFLOW_RGB (24'hFF00FF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start),
`ifdef SCANOUT_UNDERFLOW_CNT_EN
        .underflow_cnt (underflow_cnt),
`endif
        .underflow   (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel clock: sample the pop strobe mid-cycle, then advance the FWFT model after the edge.
    task automatic cycle(output logic popped);
        @(negedge clk);
        popped = fifo_rd_en;
        @(posedge clk);
        #1;
        if (popped && !fifo_empty) begin
            word++;
            fifo_dout = word[23:0];
        end
    endtask

    function automatic logic [23:0] rgb_now();
        return {red, green, blue};
    endfunction

    initial begin
        logic p;
        int   pops0, pops1, rd_bad, pix_bad, blank_bad, fs_cnt, fs_second;
        int   hs_cnt, hs_first, vs_cnt, vs_first, bl_line, idle_pops, idle_bad;
        int   k, h, v, f, ku, kr;
        logic [31:0] exp_word;

        rst = 1'b1; fifo_empty = 1'b1; word = 0; fifo_dout = '0;
        #3;
        check("rst_hsync", {31'd0, hsync}, 1);
        check("rst_vsync", {31'd0, vsync}, 1);
        check("rst_blank", {31'd0, blank}, 1);
        check("rst_rgb", {8'd0, rgb_now()}, 0);
        check("rst_fs", {31'd0, frame_start}, 0);
        check("rst_uf", {31'd0, underflow}, 0);
        check("rst_rden", {31'd0, fifo_rd_en}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // FIFO empty: must stay idle
        idle_pops = 0; idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(p);
            if (p) idle_pops++;
            if (!hsync || !vsync || !blank || rgb_now() != 0 || frame_start) idle_bad++;
        end
        check("idle_pops", idle_pops, 0);
        check("idle_outputs", idle_bad, 0);

        // Data arrives: this edge moves IDLE->RUN with no pop yet
        fifo_empty = 1'b0;
        cycle(p);
        check("start_edge_pop", {31'd0, p}, 0);

        pops0 = 0; pops1 = 0; rd_bad = 0; pix_bad = 0; blank_bad = 0;
        fs_cnt = 0; fs_second = -1; hs_cnt = 0; hs_first = -1;
        vs_cnt = 0; vs_first = -1; bl_line = 0;
        for (k = 0; k < 2 * FRM; k++) begin
            h = k % HT; v = (k / HT) % VT; f = k / FRM;
            cycle(p);
            if (p) begin
                if (f == 0) pops0++; else pops1++;
            end
            if (p != (h < HA && v < VA)) rd_bad++;
            if (h < HA && v < VA) begin
                exp_word = f * PIX + v * HA + h;
                if (rgb_now() != exp_word[23:0]) pix_bad++;
            end else if (rgb_now() != 0) pix_bad++;
            if (blank != !(h < HA && v < VA)) blank_bad++;
            if (k == 0) begin
                check("first_rgb", {8'd0, rgb_now()}, 0);
                check("first_fs", {31'd0, frame_start}, 1);
            end
            if (frame_start) begin
                fs_cnt++;
                if (k != 0) fs_second = k;
            end
            if (f == 0 && v == 0) begin
                if (!hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = h;
                end
                if (!blank) bl_line++;
            end
            if (f == 0 && !vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k;
            end
        end
        check("pops_frame0", pops0, PIX);
        check("pops_frame1", pops1, PIX);
        check("rden_pattern", rd_bad, 0);
        check("pixel_data", pix_bad, 0);
        check("blank_pattern", blank_bad, 0);
        check("fs_count", fs_cnt, 2);
        check("fs_period", fs_second, FRM);
        check("hsync_width", hs_cnt, 96);
        check("hsync_start", hs_first, 656);
        check("vsync_width", vs_cnt, 1600);
        check("vsync_start", vs_first, 5 * HT);
        check("active_line_len", bl_line, 640);
        check("no_underflow", {31'd0, underflow}, 0);

        // Starve the FIFO at pixel (100,1) of frame 2 for 3 clocks
        ku = 2 * FRM + HT + 100;
        for (; k < ku; k++) cycle(p);
        fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(p); k++;
            check($sformatf("uf_pop%0d", i), {31'd0, p}, 0);
            check($sformatf("uf_rgb%0d", i), {8'd0, rgb_now()}, 32'hFF00FF);
            if (i == 0) check("uf_flag_set", {31'd0, underflow}, 1);
        end
        fifo_empty = 1'b0;
        cycle(p); k++;
        check("uf_slip_word", {8'd0, rgb_now()}, 2 * PIX + HA + 100);
`ifdef SCANOUT_UNDERFLOW_CNT_EN
        check("uf_cnt", {16'd0, underflow_cnt}, 3);
`endif
        kr = 2 * FRM + 2 * HT + 300;
        for (; k < kr; k++) cycle(p);
        check("uf_flag_held", {31'd0, underflow}, 1);
        check("pre_rst_blank", {31'd0, blank}, 0);

        // Asynchronous reset mid-line at hcnt=300
        rst = 1'b1;
        #1;
        check("mid_rst_blank", {31'd0, blank}, 1);
        check("mid_rst_rgb", {8'd0, rgb_now()}, 0);
        check("mid_rst_hsync", {31'd0, hsync}, 1);
        check("mid_rst_uf", {31'd0, underflow}, 0);
        check("mid_rst_rden", {31'd0, fifo_rd_en}, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        fifo_empty = 1'b1;
        idle_pops = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(p);
            if (p) idle_pops++;
        end
        check("post_rst_idle_pops", idle_pops, 0);
        word = 1000;
        fifo_dout = word[23:0];
        fifo_empty = 1'b0;
        cycle(p);
        cycle(p);
        check("restart_pop", {31'd0, p}, 1);
        check("restart_rgb", {8'd0, rgb_now()}, 1000);
        check("restart_fs", {31'd0, frame_start}, 1);
        check("restart_blank", {31'd0, blank}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
